// File: rtl/sixteen_to_four_scan_encoder.sv
// Scan encoder: loads a 16-bit request vector and streams out the codes of its set bits,
// highest index first, under a ready handshake. Finishes with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; y/valid forced low
// SCAN  | offering the highest pending code, cleared on each accepted transfer
// DONE  | one-cycle completion pulse; none flags an all-zero load
module sixteen_to_four_scan_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        En,
   input  logic        start,
   input  logic [0:15] w,
   input  logic        ready,
   output logic [3:0]  y,
   output logic        valid,
   output logic        busy,
   output logic        done,
   output logic        none,
   output logic [4:0]  count
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] pending_q, pending_d;
   logic [4:0]  count_q, count_d;
   logic        none_q, none_d;
   logic [15:0] w_vec;
   logic [3:0]  top_idx;

   // w is declared ascending; remap so that pending bit i always means code i.
   always_comb begin
      w_vec = '0;
      for (int i = 0; i < 16; i++) begin
         w_vec[i] = w[i];
      end
   end

   always_comb begin
      top_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pending_q[i]) top_idx = 4'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      none_d    = none_q;
      if (En) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  pending_d = w_vec;
                  count_d   = 5'd0;
                  if (w_vec != 16'd0) begin
                     state_d = SCAN;
                     none_d  = 1'b0;
                  end else begin
                     state_d = DONE;
                     none_d  = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (ready) begin
                  pending_d[top_idx] = 1'b0;
                  if (count_q != 5'd16) count_d = count_q + 5'd1;
                  if (pending_d == 16'd0) begin
                     state_d = DONE;
                     none_d  = 1'b0;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 16'd0;
         count_q   <= 5'd0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         none_q    <= none_d;
      end
   end

   // Outputs decode straight from flops so reset clears them without a clock.
   assign valid = (state_q == SCAN);
   assign busy  = (state_q == SCAN);
   assign y     = valid ? top_idx : 4'd0;
   assign done  = (state_q == DONE);
   assign none  = done & none_q;
   assign count = count_q;

endmodule

// File: tb/tb_sixteen_to_four_scan_encoder.sv
// Self-checking bench for sixteen_to_four_scan_encoder: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of the code stream.
module tb_sixteen_to_four_scan_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        En;
   logic        start;
   logic [0:15] w;
   logic        ready;
   logic [3:0]  y;
   logic        valid, busy, done, none;
   logic [4:0]  count;

   int checks   = 0;
   int failures = 0;
   string scen  = "reset";

   // model: phase 0=idle 1=scan 2=done; q holds codes still to be sent, highest first
   int m_phase = 0;
   int m_q[$];
   int m_count = 0;
   bit m_none  = 1'b0;

   sixteen_to_four_scan_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .En    (En),
      .start (start),
      .w     (w),
      .ready (ready),
      .y     (y),
      .valid (valid),
      .busy  (busy),
      .done  (done),
      .none  (none),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s/%s got=%0d exp=%0d t=%0t", scen, tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("valid", int'(valid), (m_phase == 1) ? 1 : 0);
      chk("busy",  int'(busy),  (m_phase == 1) ? 1 : 0);
      chk("y",     int'(y),     (m_phase == 1) ? m_q[0] : 0);
      chk("done",  int'(done),  (m_phase == 2) ? 1 : 0);
      chk("none",  int'(none),  (m_phase == 2 && m_none) ? 1 : 0);
      chk("count", int'(count), m_count);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_q.delete();
      m_count = 0;
      m_none  = 1'b0;
   endtask

   task automatic model_edge(input bit en_i, input bit st_i, input logic [0:15] w_i,
                             input bit rdy_i);
      if (!en_i) return;
      case (m_phase)
         0: if (st_i) begin
            m_q.delete();
            for (int i = 15; i >= 0; i--) if (w_i[i]) m_q.push_back(i);
            m_count = 0;
            m_none  = (m_q.size() == 0);
            m_phase = (m_q.size() == 0) ? 2 : 1;
         end
         1: if (rdy_i) begin
            void'(m_q.pop_front());
            m_count++;
            if (m_q.size() == 0) m_phase = 2;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic step(input bit en_i, input bit st_i, input logic [0:15] w_i, input bit rdy_i);
      @(negedge clk);
      check_outputs();
      En    = en_i;
      start = st_i;
      w     = w_i;
      ready = rdy_i;
      model_edge(en_i, st_i, w_i, rdy_i);
      @(posedge clk);
   endtask

   function automatic logic [0:15] bits(input int a, input int b, input int c);
      logic [0:15] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [0:15] rw;
      rst_n = 1'b0;
      En    = 1'b0;
      start = 1'b0;
      w     = '0;
      ready = 1'b0;
      model_reset();
      #3;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      scen = "single";
      step(1, 1, bits(0, -1, -1), 1);
      step(1, 0, '0, 1);
      step(1, 0, '0, 1);
      step(1, 0, '0, 1);

      scen = "sparse";
      step(1, 1, bits(15, 13, 0), 1);
      for (int i = 0; i < 5; i++) step(1, 0, '0, 1);

      scen = "backpressure";
      step(1, 1, 16'hFFFF, 0);
      for (int i = 0; i < 34; i++) step(1, 0, '0, i[0]);
      step(1, 0, '0, 0);

      scen = "empty";
      step(1, 1, '0, 1);
      step(1, 0, '0, 1);
      step(1, 0, '0, 1);

      scen = "enable_stall";
      step(1, 1, bits(9, 4, 2), 1);
      step(1, 0, '0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 16'hFFFF, 1);
      for (int i = 0; i < 4; i++) step(1, 0, '0, 1);

      scen = "start_in_scan";
      step(1, 1, bits(6, 3, -1), 1);
      step(1, 1, 16'hFFFF, 1);
      step(1, 1, 16'hFFFF, 1);
      step(1, 0, '0, 0);

      scen = "async_reset";
      step(1, 1, bits(12, 8, 1), 1);
      step(1, 0, '0, 1);
      @(negedge clk);
      start = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1 rst_n = 1'b1;
      step(1, 0, '0, 1);
      step(1, 1, bits(7, -1, -1), 1);
      step(1, 0, '0, 1);
      step(1, 0, '0, 0);
      step(1, 0, '0, 0);

      scen = "random";
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0:       rw = 16'($urandom);
            1:       rw = 16'($urandom & $urandom & $urandom);
            2:       rw = '0;
            default: rw = 16'(1 << $urandom_range(0, 15));
         endcase
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), rw,
              $urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
